// File: rtl/imc_pkg.sv
// imc_pkg: shared frame geometry and FSM state type for the IMC host-side wrappers.
package imc_pkg;
    localparam int WORDS_PER_FRAME = 4;
    localparam int IDX_W = $clog2(WORDS_PER_FRAME);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);
    typedef enum logic [0:0] {Idle, Send} state_e;
endpackage

// File: rtl/output_wrapper.sv
// output_wrapper: captures a four-word IMC result frame and streams it out
// word by word over a valid/accept handshake, flagging results that arrive while busy.
module output_wrapper
    import imc_pkg::*;
#(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  done,
    input  logic [data_width-1:0] dataIna,
    input  logic [data_width-1:0] dataInb,
    input  logic [data_width-1:0] dataInc,
    input  logic [data_width-1:0] dataInd,
    output logic                  imcReady,
    output logic [data_width-1:0] dataOut,
    output logic                  dataValid,
    input  logic                  dataAccept,
    output logic                  lastWord,
    output logic                  overrun
);
    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [data_width-1:0] buf_q [WORDS_PER_FRAME];
    logic [data_width-1:0] buf_d [WORDS_PER_FRAME];
    logic                  overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= Idle;
            idx_q     <= '0;
            buf_q     <= '{default: '0};
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == Idle && done)
            state_d = Send;
        else if (state_q == Send && dataAccept && idx_q == LAST_IDX)
            state_d = Idle;
    end

    // A done seen in Send (even alongside the final accept) is dropped and recorded.
    always_comb begin
        idx_d     = idx_q;
        buf_d     = buf_q;
        overrun_d = overrun_q | (done && state_q == Send);
        if (state_q == Idle && done) begin
            idx_d = '0;
            buf_d = '{dataIna, dataInb, dataInc, dataInd};
        end else if (state_q == Send && dataAccept) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        imcReady  = (state_q == Idle);
        dataValid = (state_q == Send);
        dataOut   = (state_q == Send) ? buf_q[idx_q] : '0;
        lastWord  = (state_q == Send) && (idx_q == LAST_IDX);
        overrun   = overrun_q;
    end
endmodule
